// File: rtl/rk_seq_ctrl_if.sv
// Bundle between the round-key sequencer, the key RAM and the broadcast logic.
// master: the sequencer (rk_seq_ctrl); slave: the environment driving start/RAM/ready.
interface rk_seq_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              abort;
  logic [2:0]        alg_mode;
  logic [ADDR_W-1:0] key_base;
  logic              dec;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic [15:0]       rk0;
  logic [31:0]       rk1;
  logic [2:0]        alg_mode_o;
  logic              rk_valid;
  logic              rk_ready;
  logic [7:0]        round_idx;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, abort, alg_mode, key_base, dec, mem_rdata, rk_ready,
    output mem_rd_en, mem_addr, rk0, rk1, alg_mode_o, rk_valid, round_idx,
           busy, done, err
  );

  modport slave (
    output start, abort, alg_mode, key_base, dec, mem_rdata, rk_ready,
    input  mem_rd_en, mem_addr, rk0, rk1, alg_mode_o, rk_valid, round_idx,
           busy, done, err
  );
endinterface

// File: rtl/rk_seq_ctrl.sv
// Round-key sequencer: on start, fetches one key per round from a synchronous
// key RAM and presents it as rk0/rk1 under a valid/ready handshake.
// Optional build macro RK_SEQ_REVERSE_EN: when defined and the latched dec=1,
// keys are fetched last-to-first (key_base + R-1-round_idx).
module rk_seq_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int ROUNDS_M0 = 10,
  parameter int ROUNDS_M1 = 32,
  parameter int ROUNDS_M2 = 44,
  parameter int ROUNDS_M3 = 27,
  parameter int ROUNDS_M4 = 36
) (
  input logic          clk,
  input logic          rst,
  rk_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        mode_q;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        rounds_q;
  logic [7:0]        round_idx_q;
  logic [15:0]       rk0_q;
  logic [31:0]       rk1_q;
  logic              err_q;

  logic              start_ok;
  logic              start_bad;
  logic              load_key;
  logic              advance;
  logic              last_round;
  logic [7:0]        rounds_sel;
  logic [7:0]        offset;

`ifdef RK_SEQ_REVERSE_EN
  logic              dec_q;
`else
  logic              unused_dec;
  assign unused_dec = bus.dec;
`endif

  // Round count for the requested mode (only meaningful for modes 0..4)
  always_comb begin
    rounds_sel = '0;
    case (bus.alg_mode)
      3'd0:    rounds_sel = 8'(ROUNDS_M0);
      3'd1:    rounds_sel = 8'(ROUNDS_M1);
      3'd2:    rounds_sel = 8'(ROUNDS_M2);
      3'd3:    rounds_sel = 8'(ROUNDS_M3);
      3'd4:    rounds_sel = 8'(ROUNDS_M4);
      default: rounds_sel = '0;
    endcase
  end

  assign last_round = (round_idx_q == (rounds_q - 8'd1));

  // Table offset of the key for the current round
  always_comb begin
    offset = round_idx_q;
`ifdef RK_SEQ_REVERSE_EN
    if (dec_q) begin
      offset = rounds_q - 8'd1 - round_idx_q;
    end
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort dominates every transition out of a busy state
  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    load_key  = 1'b0;
    advance   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          if (bus.alg_mode <= 3'd4) begin
            start_ok = 1'b1;
            state_d  = S_FETCH;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      S_FETCH: begin
        state_d = bus.abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          load_key = 1'b1;
          state_d  = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.rk_ready) begin
          if (last_round) begin
            state_d = S_DONE;
          end else begin
            advance = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath: command latch, round counter, key capture and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= '0;
      base_q      <= '0;
      rounds_q    <= '0;
      round_idx_q <= '0;
      rk0_q       <= '0;
      rk1_q       <= '0;
      err_q       <= 1'b0;
`ifdef RK_SEQ_REVERSE_EN
      dec_q       <= 1'b0;
`endif
    end else begin
      err_q <= start_bad;
      if (start_ok) begin
        mode_q      <= bus.alg_mode;
        base_q      <= bus.key_base;
        rounds_q    <= rounds_sel;
        round_idx_q <= '0;
`ifdef RK_SEQ_REVERSE_EN
        dec_q       <= bus.dec;
`endif
      end
      if (advance) begin
        round_idx_q <= round_idx_q + 8'd1;
      end
      if (load_key) begin
        case (mode_q)
          3'd0: begin
            rk0_q <= {8'd0, bus.mem_rdata[7:0]};
            rk1_q <= '0;
          end
          3'd1, 3'd3: begin
            rk0_q <= bus.mem_rdata[15:0];
            rk1_q <= '0;
          end
          3'd2: begin
            rk0_q <= '0;
            rk1_q <= bus.mem_rdata;
          end
          3'd4: begin
            rk0_q <= '0;
            rk1_q <= {8'd0, bus.mem_rdata[23:0]};
          end
          default: begin
            rk0_q <= '0;
            rk1_q <= '0;
          end
        endcase
      end
    end
  end

  // Output decode from state and registered datapath
  always_comb begin
    bus.mem_rd_en  = (state_q == S_FETCH);
    bus.mem_addr   = (state_q == S_FETCH) ? (base_q + ADDR_W'(offset)) : '0;
    bus.rk_valid   = (state_q == S_PRESENT);
    bus.busy       = (state_q != S_IDLE);
    bus.done       = (state_q == S_DONE);
    bus.err        = err_q;
    bus.rk0        = rk0_q;
    bus.rk1        = rk1_q;
    bus.alg_mode_o = mode_q;
    bus.round_idx  = round_idx_q;
  end

endmodule

// File: tb/tb_rk_seq_ctrl.sv
// Randomized self-checking bench for rk_seq_ctrl with a key RAM model and a
// per-run expected key list derived from mode/base/direction.
module tb_rk_seq_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [31:0] ram [256];
  logic [2:0]  last_mode;

  rk_seq_ctrl_if #(.ADDR_W(8)) bus_if ();

  rk_seq_ctrl #(.ADDR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous key RAM: data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (bus_if.mem_rd_en) bus_if.mem_rdata <= ram[bus_if.mem_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int rounds_of(input logic [2:0] m);
    case (m)
      3'd0: return 10;
      3'd1: return 32;
      3'd2: return 44;
      3'd3: return 27;
      3'd4: return 36;
      default: return 0;
    endcase
  endfunction

  // Expected {rk0, rk1} for a RAM word in a given mode
  function automatic logic [47:0] key_of(input logic [2:0] m, input logic [31:0] w);
    case (m)
      3'd0:       return {16'(w % 256), 32'd0};
      3'd1, 3'd3: return {16'(w % 65536), 32'd0};
      3'd2:       return {16'd0, w};
      3'd4:       return {16'd0, w % 32'h0100_0000};
      default:    return '0;
    endcase
  endfunction

  function automatic logic [7:0] key_addr(input logic [7:0] base, input logic d,
                                          input int r, input int i);
    int off;
    off = i;
`ifdef RK_SEQ_REVERSE_EN
    if (d) off = r - 1 - i;
`endif
    return 8'((int'(base) + off) % 256);
  endfunction

  // Start a run at the current negedge and follow it key by key
  task automatic run(input logic [2:0] mode, input logic [7:0] base, input logic d,
                     input int abort_at, input int stall_round, input bit rnd_stall);
    int r;
    int cyc;
    int nrd;
    int stall;
    logic [7:0]  eaddr;
    logic [7:0]  addr_seen;
    logic [15:0] e0;
    logic [31:0] e1;
    r = rounds_of(mode);
    bus_if.start    = 1'b1;
    bus_if.alg_mode = mode;
    bus_if.key_base = base;
    bus_if.dec      = d;
    @(negedge clk);
    bus_if.start    = 1'b0;
    bus_if.alg_mode = 3'($urandom);
    bus_if.key_base = 8'($urandom);
    bus_if.dec      = 1'($urandom);
    last_mode = mode;
    for (int i = 0; i < r; i++) begin
      eaddr = key_addr(base, d, r, i);
      {e0, e1} = key_of(mode, ram[eaddr]);
      cyc = 0;
      nrd = 0;
      addr_seen = '0;
      while (!bus_if.rk_valid && cyc < 8) begin
        if (bus_if.mem_rd_en) begin
          nrd++;
          addr_seen = bus_if.mem_addr;
        end
        @(negedge clk);
        cyc++;
      end
      check("latency", cyc, 2);
      check("rd_count", nrd, 1);
      check("mem_addr", addr_seen, eaddr);
      check("rk_valid", bus_if.rk_valid, 1);
      check("rk0", bus_if.rk0, e0);
      check("rk1", bus_if.rk1, e1);
      check("round_idx", bus_if.round_idx, i);
      check("alg_mode_o", bus_if.alg_mode_o, mode);
      check("busy_run", bus_if.busy, 1);
      if (i == abort_at) begin
        bus_if.abort = 1'b1;
        @(negedge clk);
        bus_if.abort = 1'b0;
        check("abort_busy", bus_if.busy, 0);
        check("abort_valid", bus_if.rk_valid, 0);
        check("abort_done", bus_if.done, 0);
        check("abort_rd", bus_if.mem_rd_en, 0);
        check("abort_rk0", bus_if.rk0, e0);
        check("abort_rk1", bus_if.rk1, e1);
        return;
      end
      stall = (i == stall_round) ? 5 :
              (rnd_stall && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("stall_valid", bus_if.rk_valid, 1);
        check("stall_rk0", bus_if.rk0, e0);
        check("stall_rk1", bus_if.rk1, e1);
        check("stall_idx", bus_if.round_idx, i);
        check("stall_rd", bus_if.mem_rd_en, 0);
      end
      bus_if.rk_ready = 1'b1;
      @(negedge clk);
      bus_if.rk_ready = 1'b0;
      check("post_hs_valid", bus_if.rk_valid, 0);
      if (i == r - 1) begin
        check("done_pulse", bus_if.done, 1);
        check("done_busy", bus_if.busy, 1);
      end else begin
        check("early_done", bus_if.done, 0);
      end
    end
    @(negedge clk);
    check("done_clear", bus_if.done, 0);
    check("idle_busy", bus_if.busy, 0);
    check("idle_rd", bus_if.mem_rd_en, 0);
  endtask

  initial begin
    int r;
    int ab;
    logic [2:0] m;
    n_checks = 0;
    n_fail   = 0;
    last_mode = '0;
    for (int n = 0; n < 256; n++) ram[n] = $urandom;
    rst = 1'b1;
    bus_if.start    = 1'b0;
    bus_if.abort    = 1'b0;
    bus_if.alg_mode = '0;
    bus_if.key_base = '0;
    bus_if.dec      = 1'b0;
    bus_if.rk_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus_if.busy, 0);
    check("rst_valid", bus_if.rk_valid, 0);
    check("rst_rd", bus_if.mem_rd_en, 0);
    check("rst_addr", bus_if.mem_addr, 0);
    check("rst_rk0", bus_if.rk0, 0);
    check("rst_rk1", bus_if.rk1, 0);
    check("rst_mode", bus_if.alg_mode_o, 0);
    check("rst_idx", bus_if.round_idx, 0);
    check("rst_done", bus_if.done, 0);
    check("rst_err", bus_if.err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Mode 2, ready effectively always high
    for (int n = 0; n < 44; n++) ram[8'h10 + n] = 32'hA500_0000 + n;
    run(3'd2, 8'h10, 1'b0, -1, -1, 1'b0);

    // Mode 0 and mode 4 over a patterned table
    for (int n = 0; n < 256; n++) ram[n] = 32'h1234_5600 | n;
    run(3'd0, 8'h00, 1'b0, -1, -1, 1'b1);
    run(3'd4, 8'h40, 1'b0, -1, -1, 1'b1);

    // Mode 1, long stall in round 3; dec=1 exercises reverse when enabled
    for (int n = 0; n < 256; n++) ram[n] = $urandom;
    run(3'd1, 8'h20, 1'b1, -1, 3, 1'b0);

    // Invalid mode: error pulse only
    bus_if.start    = 1'b1;
    bus_if.alg_mode = 3'b110;
    @(negedge clk);
    bus_if.start = 1'b0;
    check("err_pulse", bus_if.err, 1);
    check("err_busy", bus_if.busy, 0);
    check("err_rd", bus_if.mem_rd_en, 0);
    check("err_mode_kept", bus_if.alg_mode_o, last_mode);
    @(negedge clk);
    check("err_clear", bus_if.err, 0);
    check("err_busy2", bus_if.busy, 0);
    run(3'd3, 8'($urandom), 1'b0, -1, -1, 1'b1);

    // Address wrap with abort in round 5, then immediate restart
    run(3'd3, 8'hF8, 1'b0, 5, -1, 1'b1);
    check("abort_no_done", bus_if.done, 0);
    run(3'd3, 8'hF8, 1'b0, -1, -1, 1'b0);

    // abort with start in IDLE: start rejected
    bus_if.start    = 1'b1;
    bus_if.abort    = 1'b1;
    bus_if.alg_mode = 3'd0;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    check("abort_start_busy", bus_if.busy, 0);
    check("abort_start_rd", bus_if.mem_rd_en, 0);
    check("abort_start_err", bus_if.err, 0);

    // Random runs
    for (int k = 0; k < 5; k++) begin
      m  = 3'($urandom_range(0, 4));
      r  = rounds_of(m);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, r - 1)) : -1;
      run(m, 8'($urandom), 1'($urandom), ab, -1, 1'b1);
      @(negedge clk);
      check("rand_idle", bus_if.busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
